// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Block-level stream interface of the iterative AES-128 engine.
//   in_valid / in_ready   : plaintext + key handshake (source -> engine)
//   plaintext, key        : 128-bit blocks, byte k = bits [8k +: 8]
//   out_valid / out_ready : ciphertext handshake (engine -> sink)
//   ciphertext            : 128-bit result, same byte ordering
//   busy                  : engine is working or holding a result
//   round                 : current round index (debug)
// The engine uses the slave modport; the surrounding system uses master.
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   plaintext;
    logic [0:127]   key;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   ciphertext;
    logic           busy;
    logic [3:0]     round;

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, round
    );

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, round
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES-128 encryption controller: one round per clock, 10 rounds,
// round keys expanded on the fly one step per round.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any block in flight
//   bus  : aes_round_ctrl_if.slave (handshakes, data, busy, round)
// Latency: accept on edge T0, rounds on T1..T10, out_valid in cycle 11.
// ---------------------------------------------------------------------------
module aes_round_ctrl (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  bus
);

    // Forward S-box, byte x at bits [8x +: 8].
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{x, 3'b000} +: 8];
    endfunction

    // Multiply by 2 in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    state_t         r_fsm;
    state_t         w_fsm_next;
    logic [0:127]   r_state;
    logic [0:127]   r_key;
    logic [7:0]     r_rcon;
    logic [3:0]     r_round;

    logic           w_last;
    logic [7:0]     w_sb [16];
    logic [7:0]     w_sr [16];
    logic [7:0]     w_mc [16];
    logic [0:127]   w_round_out;
    logic [31:0]    w_kw [4];
    logic [31:0]    w_temp;
    logic [0:127]   w_rk;

    // Final round is the one that skips MixColumns and ends the block.
    assign w_last = (r_round == 4'd10);

    // SubBytes followed by ShiftRow: out byte(r,c) = in byte(r,(c+r)%4),
    // with byte index k = 4*c + r.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
            assign w_sb[gi] = sbox(r_state[8*gi +: 8]);
            assign w_sr[gi] = w_sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
        end
    endgenerate

    // MixColumns, one column per iteration.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = w_sr[4*gi + 0];
            assign a1 = w_sr[4*gi + 1];
            assign a2 = w_sr[4*gi + 2];
            assign a3 = w_sr[4*gi + 3];
            assign w_mc[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign w_mc[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign w_mc[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign w_mc[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // Key schedule step. Each new word is the XOR of all older words up to
    // it plus the transformed w3, written out flat to avoid a chained
    // dependency through one array.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_kw
            assign w_kw[gi] = r_key[32*gi +: 32];
        end
    endgenerate

    assign w_temp = {sbox(w_kw[3][23:16]), sbox(w_kw[3][15:8]),
                     sbox(w_kw[3][7:0]),   sbox(w_kw[3][31:24])}
                    ^ {r_rcon, 24'h000000};

    assign w_rk[0:31]   = w_temp ^ w_kw[0];
    assign w_rk[32:63]  = w_temp ^ w_kw[0] ^ w_kw[1];
    assign w_rk[64:95]  = w_temp ^ w_kw[0] ^ w_kw[1] ^ w_kw[2];
    assign w_rk[96:127] = w_temp ^ w_kw[0] ^ w_kw[1] ^ w_kw[2] ^ w_kw[3];

    // AddRoundKey; the last round takes the ShiftRow output directly.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ark
            assign w_round_out[8*gi +: 8] =
                (w_last ? w_sr[gi] : w_mc[gi]) ^ w_rk[8*gi +: 8];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:  if (bus.in_valid)  w_fsm_next = S_ROUND;
            S_ROUND: if (w_last)        w_fsm_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_fsm_next = S_IDLE;
            default:                    w_fsm_next = S_IDLE;
        endcase
    end

    // State, round key, rcon and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_rcon  <= 8'h01;
            r_round <= 4'd0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= bus.plaintext ^ bus.key;
                        r_key   <= bus.key;
                        r_rcon  <= 8'h01;
                        r_round <= 4'd1;
                    end
                end
                S_ROUND: begin
                    r_state <= w_round_out;
                    r_key   <= w_rk;
                    r_rcon  <= xtime(r_rcon);
                    // Counter parks at 10 while the result is held.
                    if (!w_last) begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_round <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs are decoded from registered state only.
    assign bus.in_ready   = (r_fsm == S_IDLE);
    assign bus.out_valid  = (r_fsm == S_DONE);
    assign bus.busy       = (r_fsm == S_ROUND) || (r_fsm == S_DONE);
    assign bus.ciphertext = r_state;
    assign bus.round      = r_round;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption engine controller: accepts one 128-bit plaintext block and 128-bit cipher key per handshake and sequences the round datapath (SubBytes, ShiftRow, MixColumns, AddRoundKey) one round per clock, for 10 rounds. It generates each round key on the fly, one key-schedule step per round. It sits between the block-level stream interface and the combinational round logic, and is the only owner of the state and round-key registers.

## Interface
- Parameters: none. AES-128 only; Nr = 10 is fixed.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key present.
- in_ready  output  1  block can accept; high only in IDLE.
- plaintext  input  [0:127]  input block; byte k = bits [8k +: 8], column-major state (byte k is row k%4, column k/4).
- key  input  [0:127]  cipher key, same byte ordering.
- out_valid  output  1  ciphertext valid; held until accepted.
- out_ready  input  1  downstream accepts ciphertext.
- ciphertext  output  [0:127]  result, same byte ordering.
- busy  output  1  high in ROUND or DONE.
- round  output  4  current round index, 0 in IDLE; debug only.

## Operation
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready:
    - state_reg <= plaintext ^ key (initial AddRoundKey).
    - key_reg <= key.
    - rcon <= 8'h01.
    - round <= 1.
    - Go to ROUND.
- ROUND: each cycle applies round r = round to state_reg.
  - Round key: rk_r = KeyExpand(key_reg, rcon).
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
    - w1' = w1 ^ w0'.
    - w2' = w2 ^ w1'.
    - w3' = w3 ^ w2'.
  - rk_r is registered into key_reg in the same cycle.
  - rcon <= xtime(rcon): left shift, XOR 8'h1b if the MSB was set. Sequence is 01,02,04,08,10,20,40,80,1b,36.
  - Rounds 1–9: state_reg <= MixColumns(ShiftRow(SubBytes(state_reg))) ^ rk_r.
  - Round 10: MixColumns is bypassed, so state_reg <= ShiftRow(SubBytes(state_reg)) ^ rk_10.
  - round increments after each round. After round 10, go to DONE.
- ShiftRow: row r rotates left by r byte positions: out byte(r,c) = in byte(r,(c+r)%4).
- MixColumns: fixed matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), reduction polynomial 0x11b.
- SubBytes: 16 state S-boxes plus 4 key-schedule S-boxes, all combinational.
- DONE:
  - out_valid = 1; ciphertext = state_reg.
  - On out_ready, go to IDLE and set round <= 0.
  - ciphertext and state_reg stay stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE. There is no input queuing; in_ready = 0 stalls the source.
- plaintext and key are sampled only on the accept cycle and may change afterwards.

## Timing
- Reset values:
  - FSM = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - busy = 0.
  - round = 0.
  - ciphertext = 128'h0 (state_reg cleared).
  - key_reg = 0, rcon = 8'h01.
- Latency and throughput:
  - Accept on edge T0; rounds execute on edges T1..T10.
  - out_valid is high after edge T10, i.e. in cycle 11 counted from accept.
  - With out_ready held at 1, DONE lasts one cycle and in_ready returns in cycle 12.
  - Best-case throughput is one block per 12 cycles.
- in_ready is deasserted from the cycle after accept until the cycle after the output handshake. in_ready and out_valid are never high in the same cycle.
- out_ready asserted before DONE has no effect.
- rst asserted at any point (mid-round or in DONE with out_valid pending) aborts the operation: the next cycle shows reset values and no ciphertext is delivered. rst has priority over every handshake in the same cycle.
- No combinational path from in_valid or out_ready to any output. All outputs are registered or decoded from the FSM state.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid rising exactly 11 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check intermediate state after round 1 = a49c7ff2689f352b6b5bea43026a5049 and round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid. Ciphertext must stay constant, in_ready = 0, and further in_valid pulses are ignored. Then release -> exactly one output handshake, after which in_ready = 1.
- Back-to-back: two vectors with in_valid held high and out_ready held high -> both correct ciphertexts, second accept occurring in cycle 12 after the first accept, round counter showing 1..10 each time.
- Reset mid-operation: assert rst at round 5 for one cycle -> out_valid never asserts for that block, round = 0, in_ready = 1 the next cycle. A subsequent C.1 vector then produces the correct result.
- Input change after accept: drive random plaintext/key values in the cycles after accept -> ciphertext still matches the value for the vector sampled at accept.
